// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared types and helpers for the sequential signed divider
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Working width for the magnitude helper; operands are sign-extended into it.
    localparam int MAG_W = 32;

    // Default operand width and the matching step-counter width.
    localparam int DEF_W = 4;
    localparam int CNT_W = $clog2(DEF_W + 1);

    // Counter width for an arbitrary operand width: it must hold the value W.
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

    // Magnitude of a sign-extended value. The most negative W-bit value
    // maps to 2^(W-1), which still fits once truncated back to W unsigned bits.
    function automatic logic [MAG_W-1:0] mag(input logic signed [MAG_W-1:0] v);
        return v[MAG_W-1] ? -v : v;
    endfunction

endpackage

// File: rtl/udiv_step.sv
// rtl/udiv_step.sv - one combinational restoring-division step
//
// Ports:
//   i_rem  [W:0]   partial remainder before the step
//   i_msb          dividend bit shifted in this step
//   i_div  [W-1:0] divisor magnitude
//   o_rem  [W:0]   partial remainder after the step
//   o_qbit         quotient bit produced by the step
module udiv_step #(
    parameter int W = 4
) (
    input  logic [W:0]   i_rem,
    input  logic         i_msb,
    input  logic [W-1:0] i_div,
    output logic [W:0]   o_rem,
    output logic         o_qbit
);

    // One extra bit of headroom so the shift never loses the old top bit.
    logic [W+1:0] w_shift;
    logic [W+1:0] w_div_ext;
    logic [W+1:0] w_diff;
    logic         w_ge;

    assign w_shift   = {i_rem, i_msb};
    assign w_div_ext = {2'b00, i_div};
    assign w_diff    = w_shift - w_div_ext;
    assign w_ge      = (w_shift >= w_div_ext);

    assign o_rem  = w_ge ? (W+1)'(w_diff) : (W+1)'(w_shift);
    assign o_qbit = w_ge;

endmodule

// File: rtl/booth_radix4_divider_seq.sv
// rtl/booth_radix4_divider_seq.sv - sequential signed restoring divider, one quotient bit per clock
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   start        division request, honoured whenever no division is in flight
//   A   [W-1:0]  signed dividend, captured on the accepting edge
//   B   [W-1:0]  signed divisor, captured on the accepting edge
//   Q   [W-1:0]  signed truncating quotient, held until the next result
//   R   [W-1:0]  signed remainder carrying the sign of A
//   busy         high while the restoring steps run
//   done         one-cycle pulse when Q/R/flags are fresh
//   div_by_zero  result flag: divisor was zero
//   overflow     result flag: most-negative / -1
module booth_radix4_divider_seq
    import div_pkg::*;
#(
    parameter int W = DEF_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    output logic [W-1:0] Q,
    output logic [W-1:0] R,
    output logic         busy,
    output logic         done,
    output logic         div_by_zero,
    output logic         overflow
);

    localparam int CW = cnt_width(W);

    state_t         r_state;
    state_t         w_next_state;

    logic [CW-1:0]  r_cnt;
    logic [W:0]     r_rem;
    logic [W-1:0]   r_dvd;
    logic [W-1:0]   r_dsr;
    logic [W-2:0]   r_quo;
    logic           r_sign_q;
    logic           r_sign_r;
    logic           r_ovf_cand;
    logic [W-1:0]   r_q;
    logic [W-1:0]   r_r;
    logic           r_dbz;
    logic           r_ovf;

    logic           w_accept;
    logic           w_b_zero;
    logic           w_last;
    logic [W-1:0]   w_mag_a;
    logic [W-1:0]   w_mag_b;
    logic           w_ovf_case;
    logic [W:0]     w_next_rem;
    logic           w_qbit;
    logic [W-1:0]   w_qmag;
    logic [W-1:0]   w_rmag;
    logic [W-1:0]   w_q_fix;
    logic [W-1:0]   w_r_fix;

    assign w_b_zero   = (B == '0);
    assign w_last     = (r_cnt == CW'(1));
    assign w_mag_a    = W'(mag(MAG_W'($signed(A))));
    assign w_mag_b    = W'(mag(MAG_W'($signed(B))));
    assign w_ovf_case = (A == {1'b1, {(W-1){1'b0}}}) && (B == '1);

    udiv_step #(.W(W)) u_step (
        .i_rem  (r_rem),
        .i_msb  (r_dvd[W-1]),
        .i_div  (r_dsr),
        .o_rem  (w_next_rem),
        .o_qbit (w_qbit)
    );

    // The final quotient bit comes straight from the step, so the sign fix
    // can be registered on the same edge as the last step.
    assign w_qmag  = {r_quo, w_qbit};
    assign w_rmag  = w_next_rem[W-1:0];
    assign w_q_fix = r_sign_q ? -w_qmag : w_qmag;
    assign w_r_fix = r_sign_r ? -w_rmag : w_rmag;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_next_state = w_b_zero ? DONE : CALC;
                end
            end
            CALC: begin
                busy = 1'b1;
                if (w_last) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    w_accept     = 1'b1;
                    w_next_state = w_b_zero ? DONE : CALC;
                end else begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt      <= '0;
            r_rem      <= '0;
            r_dvd      <= '0;
            r_dsr      <= '0;
            r_quo      <= '0;
            r_sign_q   <= 1'b0;
            r_sign_r   <= 1'b0;
            r_ovf_cand <= 1'b0;
            r_q        <= '0;
            r_r        <= '0;
            r_dbz      <= 1'b0;
            r_ovf      <= 1'b0;
        end else if (w_accept) begin
            r_ovf <= 1'b0;
            r_dbz <= w_b_zero;
            if (w_b_zero) begin
                // Zero divisor bypasses CALC: the result is ready immediately.
                r_q <= '1;
                r_r <= A;
            end else begin
                r_sign_q   <= A[W-1] ^ B[W-1];
                r_sign_r   <= A[W-1];
                r_dvd      <= w_mag_a;
                r_dsr      <= w_mag_b;
                r_rem      <= '0;
                r_quo      <= '0;
                r_cnt      <= CW'(W);
                r_ovf_cand <= w_ovf_case;
            end
        end else if (r_state == CALC) begin
            r_rem <= w_next_rem;
            r_dvd <= r_dvd << 1;
            r_quo <= (W-1)'({r_quo, w_qbit});
            r_cnt <= r_cnt - CW'(1);
            if (w_last) begin
                // Overflow needs no special datapath: qmag = 2^(W-1) with a
                // positive sign already wraps to the most negative value.
                r_q   <= w_q_fix;
                r_r   <= w_r_fix;
                r_ovf <= r_ovf_cand;
            end
        end
    end

    assign Q           = r_q;
    assign R           = r_r;
    assign div_by_zero = r_dbz;
    assign overflow    = r_ovf;

endmodule

// File: tb/tb_booth_radix4_divider_seq.sv
// tb/tb_booth_radix4_divider_seq.sv - scoreboard testbench for booth_radix4_divider_seq
module tb_booth_radix4_divider_seq;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic [W-1:0] Q;
    logic [W-1:0] R;
    logic         busy;
    logic         done;
    logic         dbz;
    logic         ovf;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
        logic         ovf;
        int           a;
        int           b;
        int           cyc;
    } exp_t;

    exp_t sb[$];

    booth_radix4_divider_seq #(.W(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .A           (A),
        .B           (B),
        .Q           (Q),
        .R           (R),
        .busy        (busy),
        .done        (done),
        .div_by_zero (dbz),
        .overflow    (ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: plain signed integer arithmetic, wrapped to W bits.
    function automatic exp_t model(input int a, input int b, input int at_cyc);
        exp_t e;
        int   qi;
        int   ri;
        if (b == 0) begin
            qi = -1;
            ri = a;
        end else begin
            qi = a / b;
            ri = a % b;
        end
        e.q   = W'(qi);
        e.r   = W'(ri);
        e.dbz = (b == 0);
        e.ovf = (a == -(1 << (W - 1))) && (b == -1);
        e.a   = a;
        e.b   = b;
        e.cyc = at_cyc;
        return e;
    endfunction

    // Monitor: pops one expectation per done pulse.
    always @(negedge clk) begin
        if (!rst && done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                int   qs;
                int   rs;
                e  = sb.pop_front();
                qs = $signed(Q);
                rs = $signed(R);
                chk($sformatf("Q(%0d/%0d)", e.a, e.b), int'(Q), int'(e.q));
                chk($sformatf("R(%0d/%0d)", e.a, e.b), int'(R), int'(e.r));
                chk($sformatf("dbz(%0d/%0d)", e.a, e.b), int'(dbz), int'(e.dbz));
                chk($sformatf("ovf(%0d/%0d)", e.a, e.b), int'(ovf), int'(e.ovf));
                chk($sformatf("done_cycle(%0d/%0d)", e.a, e.b), cyc, e.cyc);
                if (!e.dbz)
                    chk($sformatf("identity(%0d/%0d)", e.a, e.b),
                        (qs * e.b + rs) & ((1 << W) - 1), e.a & ((1 << W) - 1));
            end
        end
    end

    // One isolated division; optionally pokes a new start while busy.
    task automatic do_div(input int a, input int b, input bit poke);
        int nb;
        int t;
        @(negedge clk);
        A     = W'(a);
        B     = W'(b);
        start = 1'b1;
        sb.push_back(model(a, b, cyc + 1 + ((b == 0) ? 0 : W)));
        @(negedge clk);
        start = 1'b0;
        nb = 0;
        for (t = 0; t < 30; t++) begin
            if (done) break;
            if (busy) nb++;
            if (poke && t == 1) begin
                A     = W'(3);
                B     = W'(1);
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        chk("done_seen", int'(t < 30), 1);
        chk($sformatf("busy_cycles(%0d/%0d)", a, b), nb, (b == 0) ? 0 : W);
    endtask

    task automatic reset_mid_calc();
        int nd;
        @(negedge clk);
        A     = W'(7);
        B     = W'(2);
        start = 1'b1;
        sb.push_back(model(7, 2, cyc + 1 + W));
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_Q", int'(Q), 0);
        chk("rst_R", int'(R), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_flags", int'({dbz, ovf}), 0);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        nd = 0;
        repeat (8) begin
            @(negedge clk);
            if (done) nd++;
        end
        chk("no_done_after_rst", nd, 0);
    endtask

    task automatic back_to_back(input int n);
        int a;
        int b;
        int t;
        @(negedge clk);
        a = $urandom_range(15) - 8;
        b = $urandom_range(15) - 8;
        A     = W'(a);
        B     = W'(b);
        start = 1'b1;
        sb.push_back(model(a, b, cyc + 1 + ((b == 0) ? 0 : W)));
        for (int k = 0; k < n; k++) begin
            for (t = 0; t < 30; t++) begin
                @(negedge clk);
                if (done) break;
            end
            chk("b2b_done_seen", int'(t < 30), 1);
            if (k < n - 1) begin
                a = $urandom_range(15) - 8;
                b = $urandom_range(15) - 8;
                if (b == 0) b = 3;
                A = W'(a);
                B = W'(b);
                sb.push_back(model(a, b, cyc + 1 + W));
            end else begin
                start = 1'b0;
            end
        end
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        A     = '0;
        B     = '0;
        repeat (2) @(negedge clk);
        chk("reset_Q", int'(Q), 0);
        chk("reset_R", int'(R), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_dbz", int'(dbz), 0);
        chk("reset_ovf", int'(ovf), 0);
        rst = 1'b0;

        do_div(7, 2, 1'b0);
        do_div(-7, 2, 1'b0);
        do_div(7, -2, 1'b0);
        do_div(-7, -2, 1'b0);
        do_div(-8, -1, 1'b0);
        do_div(5, 0, 1'b0);
        do_div(7, 2, 1'b1);

        reset_mid_calc();

        back_to_back(6);

        for (int a = -8; a < 8; a++)
            for (int b = -8; b < 8; b++)
                if (b != 0) do_div(a, b, 1'b0);

        for (int i = 0; i < 40; i++)
            do_div(int'($urandom_range(15)) - 8, int'($urandom_range(15)) - 8,
                   1'($urandom_range(1)));

        repeat (4) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
